mem_seq: RTL and testbench

MEM_SEQ -- requirements
Module: mem_seq

---
 rtl/mem_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// mem_seq: sequencer for one-instruction-at-a-time register/memory transfers.
// Accepts an instruction word, fetches register operands, runs a single
// memory bus transaction, writes the result back and emits a retire pulse.
// It handles LDI, LD, LDR, ST, STR, PUSH and POP. Any other opcode retires
// with a fault pulse.
//
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   ir, ir_valid, ir_ready   - instruction handshake; cond_pass is sampled with ir
//   reg_rd_sel, reg_rd_data  - combinational register read port
//   reg_wr_en/sel/data       - register write port, one cycle per write
//   mem_req/we/addr/wdata    - memory request held until mem_ack
//   mem_rdata, mem_ack       - memory response, captured on the ack cycle
//   done, fault              - retire pulse and error pulse
//   sp                       - stack pointer, wraps modulo 2^ADDR_W
//
// Build option: define MEM_SEQ_TIMEOUT_EN to abort a bus transaction that
// sees no ack within MAX_WAIT cycles. The abort pulses fault together with done.
//
// state  | meaning
// IDLE   | ready for an instruction
// OPND_B | reg_b being read (address for LDR/STR)
// OPND_A | reg_a being read (store data); PUSH decrements sp here
// BUS    | mem_req held, waiting for mem_ack
// WB     | register write (LDI/LD/LDR/POP); POP increments sp here
// DONE   | one-cycle retire, done high
module mem_seq #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] SP_INIT  = 16'h0000,
    parameter int                MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ir,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic              cond_pass,
    output logic [3:0]        reg_rd_sel,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              reg_wr_en,
    output logic [3:0]        reg_wr_sel,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              fault,
    output logic [ADDR_W-1:0] sp
);

    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_LDR  = 8'h11;
    localparam logic [7:0] OP_LDI  = 8'h12;
    localparam logic [7:0] OP_ST   = 8'h13;
    localparam logic [7:0] OP_STR  = 8'h14;
    localparam logic [7:0] OP_PUSH = 8'h15;
    localparam logic [7:0] OP_POP  = 8'h16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPND_B = 3'd1,
        OPND_A = 3'd2,
        BUS    = 3'd3,
        WB     = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] op_q;
    logic [3:0] ra_q;
    logic [3:0] rb_q;

    // The condition field is evaluated outside this block (cond_pass), and
    // addresses only ever use the low 16 bits of a register.
    logic unused_bits;
    assign unused_bits = ^{ir[31:28], reg_rd_data[DATA_W-1:16]};

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    localparam int unused_max_wait = MAX_WAIT;
`endif

    // Holding off ir_ready during reset stops an accept from being
    // reported in a cycle that the FSM will discard.
    assign ir_ready   = (state == IDLE) && !rst;
    assign reg_rd_sel = (state == OPND_B) ? rb_q : ra_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sp          <= SP_INIT;
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_sel  <= '0;
            reg_wr_data <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
            wait_cnt    <= CNT_W'(MAX_WAIT);
`endif
        end else begin
            reg_wr_en <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;

            case (state)
                IDLE: begin
                    if (ir_valid) begin
                        op_q <= ir[27:20];
                        ra_q <= ir[19:16];
                        rb_q <= ir[15:12];
                        if (!cond_pass) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            case (ir[27:20])
                                OP_LDI: begin
                                    state       <= WB;
                                    reg_wr_en   <= 1'b1;
                                    reg_wr_sel  <= ir[19:16];
                                    reg_wr_data <= DATA_W'(ir[15:0]);
                                end
                                OP_LD: begin
                                    state    <= BUS;
                                    mem_req  <= 1'b1;
                                    mem_we   <= 1'b0;
                                    mem_addr <= ADDR_W'(ir[15:0]);
                                end
                                OP_POP: begin
                                    state    <= BUS;
                                    mem_req  <= 1'b1;
                                    mem_we   <= 1'b0;
                                    mem_addr <= sp;
                                end
                                OP_LDR, OP_STR: begin
                                    state <= OPND_B;
                                end
                                OP_ST: begin
                                    state    <= OPND_A;
                                    mem_addr <= ADDR_W'(ir[15:0]);
                                end
                                OP_PUSH: begin
                                    state <= OPND_A;
                                end
                                default: begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    fault <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                OPND_B: begin
                    mem_addr <= ADDR_W'(reg_rd_data[15:0]);
                    if (op_q == OP_LDR) begin
                        state   <= BUS;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end else begin
                        state <= OPND_A;
                    end
                end

                OPND_A: begin
                    state     <= BUS;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= reg_rd_data;
                    if (op_q == OP_PUSH) begin
                        sp       <= sp - 1'b1;
                        mem_addr <= sp - 1'b1;
                    end
                end

                BUS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= WB;
                            reg_wr_en   <= 1'b1;
                            reg_wr_sel  <= ra_q;
                            reg_wr_data <= mem_rdata;
                        end
                    end
`ifdef MEM_SEQ_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(1)) begin
                        // The bus gave up: skip WB and keep any sp change made so far.
                        mem_req <= 1'b0;
                        state   <= DONE;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end

                WB: begin
                    if (op_q == OP_POP) begin
                        sp <= sp + 1'b1;
                    end
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef MEM_SEQ_TIMEOUT_EN
            // Reload the timer whenever the FSM is outside BUS. Each
            // transaction then starts with a full MAX_WAIT budget.
            if (state != BUS) begin
                wait_cnt <= CNT_W'(MAX_WAIT);
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
module tb_mem_seq;

    localparam int              MAX_WAIT = 4;
    localparam logic [15:0]     SP_INIT  = 16'h0000;

    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_LDR  = 8'h11;
    localparam logic [7:0] OP_LDI  = 8'h12;
    localparam logic [7:0] OP_ST   = 8'h13;
    localparam logic [7:0] OP_STR  = 8'h14;
    localparam logic [7:0] OP_PUSH = 8'h15;
    localparam logic [7:0] OP_POP  = 8'h16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        cond_pass;
    logic [3:0]  reg_rd_sel;
    logic [31:0] reg_rd_data;
    logic        reg_wr_en;
    logic [3:0]  reg_wr_sel;
    logic [31:0] reg_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        fault;
    logic [15:0] sp;

    // Reference state: register file, sparse memory and stack pointer.
    logic [31:0] rf [16];
    logic [31:0] mem_m [logic [15:0]];
    logic [15:0] sp_m;

    int vectors     = 0;
    int miscompares = 0;

    assign reg_rd_data = rf[reg_rd_sel];

    always #5 clk = ~clk;

    mem_seq #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .SP_INIT (SP_INIT),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .cond_pass  (cond_pass),
        .reg_rd_sel (reg_rd_sel),
        .reg_rd_data(reg_rd_data),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_sel (reg_wr_sel),
        .reg_wr_data(reg_wr_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .fault      (fault),
        .sp         (sp)
    );

    function automatic logic [31:0] mem_val(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {~a, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and compare everything it does against the
    // model. w = bus wait cycles before ack; w < 0 means the ack never comes.
    task automatic exec(input logic [7:0] op, input logic [3:0] ra, input logic [15:0] imm,
                        input logic cond, input int w, input string tag);
        logic [3:0]  rb;
        int          pre, exp_done, exp_wr_cyc, exp_req;
        logic        exp_fault, exp_wr, exp_we, is_bus, mem_upd;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdat, exp_wd;
        logic [15:0] exp_addr, sp_next;
        int          done_n, done_cyc, fault_n, wr_n, wr_cyc, req_n, bad_n, guard;
        logic [3:0]  wr_sel_o;
        logic [31:0] wr_data_o;
        logic        busy_ready, ready_after;

        rb = imm[15:12];
        pre = 0; exp_done = 0; exp_wr_cyc = 0; exp_req = 0;
        exp_fault = 1'b0; exp_wr = 1'b0; exp_we = 1'b0; is_bus = 1'b0; mem_upd = 1'b0;
        exp_sel = '0; exp_wdat = '0; exp_wd = '0; exp_addr = '0; sp_next = sp_m;

        if (!cond) begin
            exp_done = 1;
        end else begin
            case (op)
                OP_LDI: begin
                    exp_wr = 1'b1; exp_sel = ra; exp_wdat = {16'h0000, imm};
                    exp_wr_cyc = 1; exp_done = 2;
                end
                OP_LD, OP_LDR, OP_POP: begin
                    is_bus = 1'b1; exp_we = 1'b0;
                    exp_addr = (op == OP_LD) ? imm : (op == OP_LDR) ? rf[rb][15:0] : sp_m;
                    pre = (op == OP_LDR) ? 1 : 0;
                    if (op == OP_POP) sp_next = sp_m + 16'd1;
                end
                OP_ST, OP_STR, OP_PUSH: begin
                    is_bus = 1'b1; exp_we = 1'b1; exp_wd = rf[ra];
                    exp_addr = (op == OP_ST) ? imm : (op == OP_STR) ? rf[rb][15:0] : sp_m - 16'd1;
                    pre = (op == OP_STR) ? 2 : 1;
                    if (op == OP_PUSH) sp_next = sp_m - 16'd1;
                end
                default: begin
                    exp_fault = 1'b1; exp_done = 1;
                end
            endcase
            if (is_bus) begin
                if (w < 0) begin
                    exp_req = MAX_WAIT; exp_done = pre + MAX_WAIT + 1; exp_fault = 1'b1;
                end else begin
                    exp_req = w + 1;
                    if (exp_we) begin
                        exp_done = pre + w + 2; mem_upd = 1'b1;
                    end else begin
                        exp_wr = 1'b1; exp_sel = ra; exp_wdat = mem_val(exp_addr);
                        exp_wr_cyc = pre + w + 2; exp_done = pre + w + 3;
                    end
                end
            end
        end

        guard = 0;
        while (!ir_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".ready_in"}, ir_ready, 1);
        ir        = {4'($urandom), op, ra, imm};
        cond_pass = cond;
        ir_valid  = 1'b1;
        @(posedge clk);

        done_n = 0; done_cyc = -1; fault_n = 0; wr_n = 0; wr_cyc = -1; req_n = 0; bad_n = 0;
        wr_sel_o = '0; wr_data_o = '0; busy_ready = 1'b1; ready_after = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ir_valid   = 1'b0;
                busy_ready = ir_ready;
            end
            if (reg_wr_en) begin
                wr_n++; wr_cyc = k; wr_sel_o = reg_wr_sel; wr_data_o = reg_wr_data;
            end
            if (mem_req) begin
                req_n++;
                if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wd))
                    bad_n++;
            end
            if (fault) fault_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = k;
            end
            mem_ack   = mem_req && (w >= 0) && (req_n == w + 1);
            mem_rdata = mem_ack ? mem_val(mem_addr) : $urandom;
            if (done_cyc >= 0 && k > done_cyc) begin
                ready_after = ir_ready;
                break;
            end
        end
        mem_ack = 1'b0;

        check({tag, ".busy_ready"}, busy_ready, 0);
        check({tag, ".done_cyc"}, done_cyc, exp_done);
        check({tag, ".done_n"}, done_n, 1);
        check({tag, ".fault_n"}, fault_n, exp_fault);
        check({tag, ".wr_n"}, wr_n, exp_wr);
        if (exp_wr) begin
            check({tag, ".wr_sel"}, wr_sel_o, exp_sel);
            check({tag, ".wr_data"}, wr_data_o, exp_wdat);
            check({tag, ".wr_cyc"}, wr_cyc, exp_wr_cyc);
        end
        check({tag, ".req_cycles"}, req_n, exp_req);
        if (exp_req > 0) check({tag, ".bus_bad_cycles"}, bad_n, 0);
        check({tag, ".sp"}, sp, sp_next);
        check({tag, ".ready_out"}, ready_after, 1);

        if (exp_wr) rf[exp_sel] = exp_wdat;
        if (mem_upd) mem_m[exp_addr] = exp_wd;
        sp_m = sp_next;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ir = '0; ir_valid = 1'b0; cond_pass = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        sp_m = SP_INIT;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.ir_ready", ir_ready, 1);
        check("reset.sp", sp, SP_INIT);
        check("reset.mem_req", mem_req, 0);
        check("reset.reg_wr_en", reg_wr_en, 0);
        check("reset.done", done, 0);
        check("reset.fault", fault, 0);

        exec(OP_LDI, 4'd3, 16'hBEEF, 1'b1, 0, "ldi_r3");

        rf[2] = 32'h0000_0040;
        rf[5] = 32'hCAFE_F00D;
        exec(OP_STR, 4'd5, 16'h2000, 1'b1, 3, "str_r5_r2");

        rf[1] = 32'h1111_1111;
        exec(OP_PUSH, 4'd1, 16'h0000, 1'b1, 1, "push_wrap");
        exec(OP_POP, 4'd4, 16'h0000, 1'b1, 0, "pop_wrap");
        check("pop_wrap.r4", rf[4], 32'h1111_1111);

        exec(8'h30, 4'd1, 16'h0055, 1'b1, 0, "illegal_30");
        exec(OP_LD, 4'd7, 16'h0100, 1'b0, 0, "ld_nocond");

        // A stray ack with no request outstanding must do nothing.
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack.mem_req", mem_req, 0);
        check("idle_ack.done", done, 0);
        check("idle_ack.reg_wr_en", reg_wr_en, 0);
        check("idle_ack.ir_ready", ir_ready, 1);

        for (int n = 0; n < 200; n++) begin
            int          sel;
            logic [7:0]  op;
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = OP_LDI;
                1: op = OP_LD;
                2: op = OP_LDR;
                3: op = OP_ST;
                4: op = OP_STR;
                5: op = OP_PUSH;
                6: op = OP_POP;
                7: op = OP_POP;
                8: op = 8'($urandom_range(8'h17, 8'hFF));
                default: op = OP_LDR;
            endcase
            exec(op, 4'($urandom), 16'($urandom), ($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 3)), "rand");
        end

`ifdef MEM_SEQ_TIMEOUT_EN
        exec(OP_LD, 4'd6, 16'h1234, 1'b1, -1, "timeout_ld");
        exec(OP_PUSH, 4'd2, 16'h0000, 1'b1, -1, "timeout_push");
`endif

        // Reset in the middle of a POP bus phase.
        while (sp_m == SP_INIT) exec(OP_PUSH, 4'd0, 16'h0000, 1'b1, 0, "pre_rst_push");
        ir = {4'h0, OP_POP, 4'd9, 16'h0000}; cond_pass = 1'b1; ir_valid = 1'b1;
        @(negedge clk);
        ir_valid = 1'b0;
        check("rst_mid.mem_req_before", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.mem_req", mem_req, 0);
        check("rst_mid.sp", sp, SP_INIT);
        check("rst_mid.reg_wr_en", reg_wr_en, 0);
        check("rst_mid.done", done, 0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        check("rst_mid.ir_ready", ir_ready, 1);
        check("rst_mid.mem_req_after", mem_req, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_mid.late_ack_wr", reg_wr_en, 0);
        check("rst_mid.late_ack_done", done, 0);
        check("rst_mid.sp_after", sp, SP_INIT);
        sp_m = SP_INIT;

        exec(OP_LDI, 4'd8, 16'h1357, 1'b1, 0, "post_rst_ldi");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
